// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles the fetch-stage control, load port and fetched-instruction outputs.
//
//   Control / load (master -> slave):
//     stall, branch_taken, branch_target[31:0], ld_en, ld_addr[AW-1:0],
//     ld_data[31:0]
//   Fetch results (slave -> master):
//     Ins[31:0], ins_pc[31:0], ins_valid, pc[31:0], halted, fault
//
//   The fetch unit connects through the slave modport; the pipeline control
//   (or a testbench) drives the master modport.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int IMEM_DEPTH = 64
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic          stall;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;

    logic [31:0]   Ins;
    logic [31:0]   ins_pc;
    logic          ins_valid;
    logic [31:0]   pc;
    logic          halted;
    logic          fault;

    modport master (
        output stall, branch_taken, branch_target, ld_en, ld_addr, ld_data,
        input  Ins, ins_pc, ins_valid, pc, halted, fault
    );

    modport slave (
        input  stall, branch_taken, branch_target, ld_en, ld_addr, ld_data,
        output Ins, ins_pc, ins_valid, pc, halted, fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage: program counter plus a loadable instruction memory. One
//   registered instruction per cycle, with stall, branch redirect (one flush
//   bubble), a halt instruction and an out-of-range fetch fault.
//
//   Ports:
//     clk   - rising-edge clock
//     rst   - synchronous active-high reset (memory contents are kept)
//     fif   - instr_fetch_unit_if.slave: control, load port, fetch outputs
//
//   Parameters:
//     IMEM_DEPTH - words of instruction memory (power of two, <= 1024)
//     RESET_PC   - word-aligned PC after reset
//     HALT_WORD  - encoding that stops fetch after being delivered
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = 32'hFC00_0000
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.slave  fif
);
    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    logic [31:0] imem [IMEM_DEPTH];

    state_t      state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] ins_q,       ins_d;
    logic [31:0] ins_pc_q,    ins_pc_d;
    logic        ins_valid_q, ins_valid_d;
    logic        halted_q,    halted_d;
    logic        fault_q,     fault_d;

    logic [AW-1:0] word_idx;
    logic          in_range;
    logic [31:0]   rd_word;
    logic          unused_tgt_lsbs;

    // Byte offset of the redirect target is discarded.
    assign unused_tgt_lsbs = ^fif.branch_target[1:0];

    // Depth is a power of two, so "word index < depth" reduces to the
    // upper PC bits all being zero.
    assign word_idx = pc_q[AW+1:2];
    assign in_range = (pc_q[31:AW+2] == '0);

    // Loads are honoured in every state, reset included.
    always_ff @(posedge clk) begin
        if (fif.ld_en) begin
            imem[fif.ld_addr] <= fif.ld_data;
        end
    end

    // Combinational read of the pre-edge contents gives read-before-write
    // behaviour when the fetch and a load hit the same word.
    assign rd_word = imem[word_idx];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        ins_pc_d    = ins_pc_q;
        ins_valid_d = ins_valid_q;
        halted_d    = halted_q;
        fault_d     = fault_q;

        case (state_q)
            RUN: begin
                if (fif.branch_taken) begin
                    // Redirect wins over stall and inserts one bubble.
                    pc_d        = {fif.branch_target[31:2], 2'b00};
                    ins_d       = '0;
                    ins_valid_d = 1'b0;
                end else if (!fif.stall) begin
                    if (in_range) begin
                        ins_d       = rd_word;
                        ins_pc_d    = pc_q;
                        ins_valid_d = 1'b1;
                        pc_d        = pc_q + 32'd4;
                        if (rd_word == HALT_WORD) begin
                            state_d = HALTED;
                        end
                    end else begin
                        // PC holds at the faulting address for debug.
                        ins_d       = '0;
                        ins_valid_d = 1'b0;
                        fault_d     = 1'b1;
                        state_d     = HALTED;
                    end
                end
            end
            HALTED: begin
                // halted is registered here, so it rises one edge after the
                // halt word (or fault) was seen.
                halted_d    = 1'b1;
                ins_d       = '0;
                ins_valid_d = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            ins_q       <= '0;
            ins_pc_q    <= '0;
            ins_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            ins_pc_q    <= ins_pc_d;
            ins_valid_q <= ins_valid_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
        end
    end

    assign fif.Ins       = ins_q;
    assign fif.ins_pc    = ins_pc_q;
    assign fif.ins_valid = ins_valid_q;
    assign fif.pc        = pc_q;
    assign fif.halted    = halted_q;
    assign fif.fault     = fault_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Cycle-level reference model plus scoreboard for instr_fetch_unit.
//   Each step drives inputs, pushes the model's expected post-edge outputs,
//   then pops and compares them one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    localparam int          DEPTH = 64;
    localparam logic [31:0] HALT  = 32'hFC00_0000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.IMEM_DEPTH(DEPTH)) fif ();

    instr_fetch_unit #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'h0000_0000),
        .HALT_WORD  (HALT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fif (fif)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] ins_pc;
        logic [31:0] pc;
        logic        valid;
        logic        halted;
        logic        fault;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec    = 0;
    int   n_miscmp = 0;
    int   cyc      = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_ins, m_ins_pc;
    logic        m_valid, m_halted, m_fault, m_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miscmp++;
            $display("FAIL %s cycle %0d: got %h, want %h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic step(input logic r, input logic st, input logic br,
                        input logic [31:0] tgt, input logic le,
                        input logic [5:0] la, input logic [31:0] ld);
        exp_t e;
        exp_t got;
        rst               = r;
        fif.stall         = st;
        fif.branch_taken  = br;
        fif.branch_target = tgt;
        fif.ld_en         = le;
        fif.ld_addr       = la;
        fif.ld_data       = ld;

        // Model of one clock edge, written from the behavioural description.
        if (r) begin
            m_pc = 32'h0; m_ins = 32'h0; m_ins_pc = 32'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_run = 1'b1;
        end else if (!m_run) begin
            m_halted = 1'b1; m_valid = 1'b0; m_ins = 32'h0;
        end else if (br) begin
            m_pc = {tgt[31:2], 2'b00}; m_ins = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
            if (m_pc < 32'(DEPTH * 4)) begin
                m_ins    = m_mem[m_pc >> 2];
                m_ins_pc = m_pc;
                m_valid  = 1'b1;
                m_pc     = m_pc + 32'd4;
                if (m_ins == HALT) m_run = 1'b0;
            end else begin
                m_ins = 32'h0; m_valid = 1'b0; m_fault = 1'b1; m_run = 1'b0;
            end
        end
        if (le) m_mem[la] = ld;

        e.ins = m_ins; e.ins_pc = m_ins_pc; e.pc = m_pc;
        e.valid = m_valid; e.halted = m_halted; e.fault = m_fault;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        got = sb_q.pop_front();
        chk("Ins",       fif.Ins,              got.ins);
        chk("ins_pc",    fif.ins_pc,           got.ins_pc);
        chk("pc",        fif.pc,               got.pc);
        chk("ins_valid", 32'(fif.ins_valid),   32'(got.valid));
        chk("halted",    32'(fif.halted),      32'(got.halted));
        chk("fault",     32'(fif.fault),       32'(got.fault));
        $display("cyc %0d rst=%b stall=%b br=%b tgt=%h ld=%b | pc=%h ins_pc=%h Ins=%h v=%b h=%b f=%b",
                 cyc, r, st, br, tgt, le, fif.pc, fif.ins_pc, fif.Ins,
                 fif.ins_valid, fif.halted, fif.fault);
    endtask

    // Plain idle fetch cycle
    task automatic run1();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
    endtask

    initial begin
        logic [31:0] prog [4];
        logic [31:0] word;
        prog[0] = 32'h0000_0400;
        prog[1] = 32'h0000_0440;
        prog[2] = 32'h0000_08C0;
        prog[3] = 32'h0000_0D40;

        rst = 1'b1;
        fif.stall = 1'b0; fif.branch_taken = 1'b0; fif.branch_target = 32'h0;
        fif.ld_en = 1'b0; fif.ld_addr = '0; fif.ld_data = 32'h0;

        // Fill the whole memory while in reset; checks reset outputs each cycle.
        for (int i = 0; i < DEPTH; i++) begin
            word = (i < 4) ? prog[i] : (32'h0000_1000 + 32'(i));
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 6'(i), word);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
        chk("rst_pc", fif.pc, 32'h0);

        // Straight-line fetch
        run1();
        chk("first_ins", fif.Ins, 32'h0000_0400);
        chk("first_valid", 32'(fif.ins_valid), 32'd1);
        run1();
        chk("second_ins_pc", fif.ins_pc, 32'h4);

        // Stall 3 cycles while ins_pc = 4
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
            chk("stall_pc", fif.pc, 32'h8);
            chk("stall_ins_pc", fif.ins_pc, 32'h4);
        end
        run1();
        chk("resume_ins", fif.Ins, 32'h0000_08C0);

        // Redirect with stall asserted in the same cycle
        step(1'b0, 1'b1, 1'b1, 32'h0000_0013, 1'b0, 6'd0, 32'h0);
        chk("redir_pc", fif.pc, 32'h10);
        chk("redir_bubble", 32'(fif.ins_valid), 32'd0);
        run1();
        chk("redir_ins_pc", fif.ins_pc, 32'h10);

        // Load collision on word 2
        step(1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 6'd0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 6'd2, 32'h1234_5678);
        chk("collide_old", fif.Ins, 32'h0000_08C0);
        step(1'b0, 1'b0, 1'b1, 32'h8, 1'b0, 6'd0, 32'h0);
        run1();
        chk("collide_new", fif.Ins, 32'h1234_5678);

        // Halt word at index 5, loaded together with a branch to word 4
        step(1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 6'd5, HALT);
        run1();
        run1();
        chk("halt_ins", fif.Ins, HALT);
        chk("halt_ins_pc", fif.ins_pc, 32'd20);
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 6'd0, 32'h0);
        chk("halted_flag", 32'(fif.halted), 32'd1);
        chk("halted_pc", fif.pc, 32'd24);
        step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 6'd6, 32'hABCD_0006);
        chk("halted_pc_hold", fif.pc, 32'd24);

        // Out-of-range fault via branch to 0x100
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 6'd0, 32'h0);
        run1();
        chk("fault_flag", 32'(fif.fault), 32'd1);
        run1();
        chk("fault_halted", 32'(fif.halted), 32'd1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 6'd0, 32'h0);
        chk("fault_cleared", 32'(fif.fault), 32'd0);
        run1();
        chk("restart_ins", fif.Ins, 32'h0000_0400);

        // Randomised traffic; occasional resets escape halted/fault states.
        for (int i = 0; i < 300; i++) begin
            logic        r_r, r_st, r_br, r_le;
            logic [31:0] r_tgt, r_ld;
            logic [5:0]  r_la;
            r_r   = ($urandom_range(0, 24) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_br  = ($urandom_range(0, 5) == 0);
            r_tgt = $urandom_range(0, 32'h120);
            r_le  = ($urandom_range(0, 2) == 0);
            r_la  = 6'($urandom_range(0, DEPTH - 1));
            r_ld  = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
            step(r_r, r_st, r_br, r_tgt, r_le, r_la, r_ld);
        end

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage for the single-cycle CPU. It holds the program counter and a loadable instruction memory, and presents one registered instruction word per cycle on `Ins`, which feeds the decode/register-file/ALU datapath directly downstream. It supports pipeline stall, branch/jump redirect with a one-cycle flush, a halt instruction, and an out-of-range fetch fault.

## Interface
- `IMEM_DEPTH`, default 64: instruction memory depth in 32-bit words; must be a power of two, at most 1024.
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; word-aligned.
- `HALT_WORD`, default 32'hFC00_0000: instruction encoding that halts fetch.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold PC and all outputs this cycle.
- `branch_taken`  in  1: redirect fetch this cycle.
- `branch_target`  in  32: byte address of the redirect; bits [1:0] are ignored.
- `ld_en`  in  1: instruction memory write enable.
- `ld_addr`  in  log2(IMEM_DEPTH): word index to write.
- `ld_data`  in  32: instruction word to write.
- `Ins`  out  32: fetched instruction (registered).
- `ins_pc`  out  32: byte address of `Ins`.
- `ins_valid`  out  1: `Ins` is a real instruction; 0 means NOP bubble.
- `pc`  out  32: address of the next fetch.
- `halted`  out  1: fetch stopped (halt or fault).
- `fault`  out  1: sticky flag for an out-of-range fetch.

## Operation
- FSM with two states, RUN and HALTED. Reset enters RUN.
- Reset values: `pc`=RESET_PC, `Ins`=0, `ins_pc`=0, `ins_valid`=0, `halted`=0, `fault`=0. Memory contents are not cleared by reset.
- Priority in RUN, highest first: `rst` > `branch_taken` > `stall` > normal fetch.
- Normal fetch, for word index w = pc[31:2]:
  - If w < IMEM_DEPTH: `Ins`<=imem[w], `ins_pc`<=pc, `ins_valid`<=1, `pc`<=pc+4 (32-bit add, modulo 2^32).
  - Otherwise: `Ins`<=0, `ins_valid`<=0, `fault`<=1, go to HALTED. `pc` holds.
- Halt: if imem[w]==HALT_WORD, the halt word is still delivered with `ins_valid`=1 and `pc` advances. The FSM then enters HALTED.
- `branch_taken`: `pc`<={branch_target[31:2],2'b00}, `Ins`<=0, `ins_valid`<=0. This is a flush bubble and applies even when `stall`=1.
- `stall` (no redirect): `pc`, `Ins`, `ins_pc` and `ins_valid` all hold.
- HALTED: `halted`=1, `pc` frozen, `ins_valid`<=0 from the next cycle, `Ins`<=0. `branch_taken` and `stall` are ignored. Only `rst` exits this state.
- Load port works in every state, including during reset. A write to imem[ld_addr] takes effect at the clock edge.
- Read-before-write: a fetch of the same word in the same cycle as a write returns the old contents.

## Timing
- Fetch latency is 1 cycle: the PC value present at edge N yields `Ins`/`ins_pc` valid after edge N.
- Throughput is 1 instruction/cycle with no stall or redirect.
- Redirect costs exactly 1 bubble cycle. The first target instruction appears 2 edges after `branch_taken` is sampled.
- `halted` rises on the edge after the one that delivered HALT_WORD (or after the fault edge). `ins_valid` is 0 from that edge onward.
- Reset mid-operation: all outputs return to their reset values on the next edge. The memory is kept, so the program reruns from RESET_PC.
- The PC wraps from 32'hFFFF_FFFC to 0. This is unreachable with default depth because the fault fires first.

## Test plan
- Reset, then run with no stall: load words 0..3 = 32'h0000_0400, 32'h0000_0440, 32'h0000_08C0, 32'h0000_0D40, hold rst 2 cycles, release → `Ins` sequence matches memory order, `ins_pc`=0,4,8,12, `ins_valid`=1 from the first edge after release.
- Stall: assert `stall` for 3 cycles while `ins_pc`=4 → `Ins`, `ins_pc` and `pc`=8 hold for 3 cycles, then fetch resumes at 8.
- Redirect: `branch_taken`=1, `branch_target`=32'h0000_0013, with `stall`=1 in the same cycle → next `ins_valid`=0 and `pc`=32'h10; the following cycle gives `ins_pc`=32'h10.
- Halt: HALT_WORD at word 5 → `Ins`=32'hFC00_0000 with `ins_valid`=1 and `ins_pc`=20; next edge `halted`=1 and `ins_valid`=0; `pc` stays at 24 despite `branch_taken`.
- Fault: branch to 32'h0000_0100 with IMEM_DEPTH=64 → `fault`=1, `halted`=1, `ins_valid`=0; `rst` clears both flags and fetch restarts at 0.
- Load collision: write word 2 := 32'h1234_5678 in the same cycle word 2 is fetched → `Ins` shows the old word; refetching word 2 after a branch to 8 gives 32'h1234_5678.
